fu_result_arbiter: RTL and testbench

- Transmit side of the functional-unit-to-ROB result interface.
- Accepts completed results from the ALU and load/store units, buffers each source in a small FIFO, and round-robin arbitrates onto the single ROB writeback/broadcast port (done, dst ROB index, value, set_nzcv, nzcv, is_mispred).
- Applies per-source backpressure through ready signals, so both units may finish in the same cycle without loss.

---
 rtl/fu_result_arbiter_if.sv | 47 ++++
 rtl/fu_result_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_fu_result_arbiter.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/fu_result_arbiter_if.sv
// Result bundle between the ALU/LS execution units and the ROB writeback port.
// The arbiter connects through the slave modport; the producing side uses master.
interface fu_result_arbiter_if #(
  parameter int GPR_SIZE     = 64,
  parameter int ROB_IDX_SIZE = 4
);
  logic                    in_flush;
  logic                    in_alu_done;
  logic [ROB_IDX_SIZE-1:0] in_alu_dst_rob_index;
  logic [GPR_SIZE-1:0]     in_alu_value;
  logic                    in_alu_set_nzcv;
  logic [3:0]              in_alu_nzcv;
  logic                    in_alu_is_mispred;
  logic                    out_alu_ready;
  logic                    in_ls_done;
  logic [ROB_IDX_SIZE-1:0] in_ls_dst_rob_index;
  logic [GPR_SIZE-1:0]     in_ls_value;
  logic                    out_ls_ready;
  logic                    out_rob_done;
  logic [ROB_IDX_SIZE-1:0] out_rob_dst_rob_index;
  logic [GPR_SIZE-1:0]     out_rob_value;
  logic                    out_rob_set_nzcv;
  logic [3:0]              out_rob_nzcv;
  logic                    out_rob_is_mispred;

  modport master (
    output in_flush,
    output in_alu_done, in_alu_dst_rob_index, in_alu_value,
    output in_alu_set_nzcv, in_alu_nzcv, in_alu_is_mispred,
    input  out_alu_ready,
    output in_ls_done, in_ls_dst_rob_index, in_ls_value,
    input  out_ls_ready,
    input  out_rob_done, out_rob_dst_rob_index, out_rob_value,
    input  out_rob_set_nzcv, out_rob_nzcv, out_rob_is_mispred
  );

  modport slave (
    input  in_flush,
    input  in_alu_done, in_alu_dst_rob_index, in_alu_value,
    input  in_alu_set_nzcv, in_alu_nzcv, in_alu_is_mispred,
    output out_alu_ready,
    input  in_ls_done, in_ls_dst_rob_index, in_ls_value,
    output out_ls_ready,
    output out_rob_done, out_rob_dst_rob_index, out_rob_value,
    output out_rob_set_nzcv, out_rob_nzcv, out_rob_is_mispred
  );
endinterface

// File: rtl/fu_result_arbiter.sv
// Buffers ALU and LS results in per-source FIFOs and round-robins them onto the
// single registered ROB writeback port. Flush and reset discard everything buffered.
module fu_result_arbiter #(
  parameter int GPR_SIZE     = 64,
  parameter int ROB_IDX_SIZE = 4,
  parameter int FIFO_DEPTH   = 2
) (
  input logic                in_clk,
  input logic                in_rst,
  fu_result_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR_C = PTR_W'(FIFO_DEPTH - 1);
  localparam int NSRC = 2;

  typedef struct packed {
    logic [ROB_IDX_SIZE-1:0] idx;
    logic [GPR_SIZE-1:0]     value;
    logic                    set_nzcv;
    logic [3:0]              nzcv;
    logic                    is_mispred;
  } entry_t;

  // Pointer holds the source granted most recently; the other source wins a tie.
  typedef enum logic {
    RR_ALU = 1'b0,
    RR_LS  = 1'b1
  } rr_e;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    logic [PTR_W-1:0] nxt;
    if (ptr == LAST_PTR_C) begin
      nxt = '0;
    end else begin
      nxt = ptr + PTR_W'(1);
    end
    return nxt;
  endfunction

  entry_t           mem_q    [NSRC][FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q [NSRC];
  logic [PTR_W-1:0] rd_ptr_d [NSRC];
  logic [PTR_W-1:0] wr_ptr_q [NSRC];
  logic [PTR_W-1:0] wr_ptr_d [NSRC];
  logic [CNT_W-1:0] cnt_q    [NSRC];
  logic [CNT_W-1:0] cnt_d    [NSRC];

  entry_t in_entry_s   [NSRC];
  logic   done_s       [NSRC];
  logic   ready_s      [NSRC];
  logic   push_s       [NSRC];
  logic   pop_s        [NSRC];
  logic   nonempty_s   [NSRC];

  logic   gnt_valid_s;
  logic   gnt_src_s;
  entry_t head_s;

  rr_e    rr_q, rr_d;
  entry_t out_q, out_d;
  logic   out_done_q, out_done_d;

  // Map the unit inputs to common entries; LS results never carry flags or mispredicts.
  always_comb begin
    in_entry_s[0]            = '0;
    in_entry_s[0].idx        = bus.in_alu_dst_rob_index;
    in_entry_s[0].value      = bus.in_alu_value;
    in_entry_s[0].set_nzcv   = bus.in_alu_set_nzcv;
    in_entry_s[0].nzcv       = bus.in_alu_nzcv;
    in_entry_s[0].is_mispred = bus.in_alu_is_mispred;
    in_entry_s[1]            = '0;
    in_entry_s[1].idx        = bus.in_ls_dst_rob_index;
    in_entry_s[1].value      = bus.in_ls_value;
    done_s[0]                = bus.in_alu_done;
    done_s[1]                = bus.in_ls_done;
  end

  // Ready depends only on the registered count, so a same-cycle pop cannot raise it.
  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      ready_s[i]    = (cnt_q[i] < DEPTH_C);
      nonempty_s[i] = (cnt_q[i] != '0);
      push_s[i]     = done_s[i] && ready_s[i] && !bus.in_flush;
    end
  end

  // Round-robin grant on the FIFO heads; a flush suppresses any pending grant.
  always_comb begin
    gnt_valid_s = 1'b0;
    gnt_src_s   = 1'b0;
    if (bus.in_flush) begin
      gnt_valid_s = 1'b0;
    end else if (nonempty_s[0] && nonempty_s[1]) begin
      gnt_valid_s = 1'b1;
      case (rr_q)
        RR_ALU:  gnt_src_s = 1'b1;
        RR_LS:   gnt_src_s = 1'b0;
        default: gnt_src_s = 1'b0;
      endcase
    end else if (nonempty_s[0]) begin
      gnt_valid_s = 1'b1;
      gnt_src_s   = 1'b0;
    end else if (nonempty_s[1]) begin
      gnt_valid_s = 1'b1;
      gnt_src_s   = 1'b1;
    end else begin
      gnt_valid_s = 1'b0;
    end
    pop_s[0] = gnt_valid_s && !gnt_src_s;
    pop_s[1] = gnt_valid_s && gnt_src_s;
    head_s   = mem_q[gnt_src_s][rd_ptr_q[gnt_src_s]];
  end

  // FIFO bookkeeping: flush empties both queues, otherwise push/pop move the pointers.
  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      cnt_d[i]    = cnt_q[i];
      rd_ptr_d[i] = rd_ptr_q[i];
      wr_ptr_d[i] = wr_ptr_q[i];
      if (bus.in_flush) begin
        cnt_d[i]    = '0;
        rd_ptr_d[i] = '0;
        wr_ptr_d[i] = '0;
      end else begin
        if (push_s[i] && !pop_s[i]) begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end else if (!push_s[i] && pop_s[i]) begin
          cnt_d[i] = cnt_q[i] - CNT_W'(1);
        end else begin
          cnt_d[i] = cnt_q[i];
        end
        if (push_s[i]) begin
          wr_ptr_d[i] = ptr_inc(wr_ptr_q[i]);
        end else begin
          wr_ptr_d[i] = wr_ptr_q[i];
        end
        if (pop_s[i]) begin
          rd_ptr_d[i] = ptr_inc(rd_ptr_q[i]);
        end else begin
          rd_ptr_d[i] = rd_ptr_q[i];
        end
      end
    end
  end

  // Round-robin pointer next state and the output register contents.
  always_comb begin
    rr_d       = rr_q;
    out_d      = '0;
    out_done_d = 1'b0;
    if (gnt_valid_s) begin
      rr_d       = gnt_src_s ? RR_LS : RR_ALU;
      out_d      = head_s;
      out_done_d = 1'b1;
    end else begin
      rr_d       = rr_q;
      out_d      = '0;
      out_done_d = 1'b0;
    end
  end

  // Control state; reset takes priority over flush and re-arms the ALU to win first.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      for (int i = 0; i < NSRC; i++) begin
        cnt_q[i]    <= '0;
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
      end
      rr_q       <= RR_LS;
      out_q      <= '0;
      out_done_q <= 1'b0;
    end else begin
      for (int i = 0; i < NSRC; i++) begin
        cnt_q[i]    <= cnt_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        wr_ptr_q[i] <= wr_ptr_d[i];
      end
      rr_q       <= rr_d;
      out_q      <= out_d;
      out_done_q <= out_done_d;
    end
  end

  // FIFO storage; entries are only read while counted, so no reset is needed.
  always_ff @(posedge in_clk) begin
    for (int i = 0; i < NSRC; i++) begin
      if (!in_rst && push_s[i]) begin
        mem_q[i][wr_ptr_q[i]] <= in_entry_s[i];
      end
    end
  end

  assign bus.out_alu_ready         = ready_s[0];
  assign bus.out_ls_ready          = ready_s[1];
  assign bus.out_rob_done          = out_done_q;
  assign bus.out_rob_dst_rob_index = out_q.idx;
  assign bus.out_rob_value         = out_q.value;
  assign bus.out_rob_set_nzcv      = out_q.set_nzcv;
  assign bus.out_rob_nzcv          = out_q.nzcv;
  assign bus.out_rob_is_mispred    = out_q.is_mispred;
endmodule

// File: tb/tb_fu_result_arbiter.sv
// Randomised scoreboard bench for fu_result_arbiter: a queue-level model predicts
// every ROB writeback and the per-source readiness, and a monitor checks them.
module tb_fu_result_arbiter;
  localparam int GPR   = 64;
  localparam int IDX   = 4;
  localparam int DEPTH = 2;

  typedef struct {
    logic [IDX-1:0] idx;
    logic [GPR-1:0] value;
    logic           set_nzcv;
    logic [3:0]     nzcv;
    logic           mis;
    int             due;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fu_result_arbiter_if #(.GPR_SIZE(GPR), .ROB_IDX_SIZE(IDX)) bus ();

  fu_result_arbiter #(.GPR_SIZE(GPR), .ROB_IDX_SIZE(IDX), .FIFO_DEPTH(DEPTH)) dut (
    .in_clk(clk),
    .in_rst(rst),
    .bus   (bus)
  );

  res_t alu_q[$];
  res_t ls_q[$];
  res_t exp_q[$];
  bit   last_ls  = 1'b1;
  int   edge_cnt = 0;
  bit   started  = 1'b0;
  int   n_cmp    = 0;
  int   n_bad    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s edge %0d: actual=%0h required=%0h", name, edge_cnt, act, req);
    end
  endtask

  // Reference model: called right after each rising edge with the inputs sampled at it.
  task automatic model_step();
    res_t e;
    bit   a_acc, l_acc;
    int   g;
    edge_cnt++;
    chk("alu_protocol", 64'(bus.in_alu_done && alu_q.size() >= DEPTH), 64'd0);
    chk("ls_protocol", 64'(bus.in_ls_done && ls_q.size() >= DEPTH), 64'd0);
    if (rst) begin
      alu_q.delete();
      ls_q.delete();
      last_ls = 1'b1;
      started = 1'b1;
      return;
    end
    if (bus.in_flush) begin
      alu_q.delete();
      ls_q.delete();
      return;
    end
    a_acc = bus.in_alu_done && (alu_q.size() < DEPTH);
    l_acc = bus.in_ls_done && (ls_q.size() < DEPTH);
    g = -1;
    if (alu_q.size() > 0 && ls_q.size() > 0) g = last_ls ? 0 : 1;
    else if (alu_q.size() > 0) g = 0;
    else if (ls_q.size() > 0) g = 1;
    if (g == 0) e = alu_q.pop_front();
    if (g == 1) e = ls_q.pop_front();
    if (g >= 0) begin
      e.due   = edge_cnt;
      exp_q.push_back(e);
      last_ls = (g == 1);
    end
    if (a_acc) begin
      e.idx = bus.in_alu_dst_rob_index; e.value = bus.in_alu_value;
      e.set_nzcv = bus.in_alu_set_nzcv; e.nzcv = bus.in_alu_nzcv;
      e.mis = bus.in_alu_is_mispred; e.due = 0;
      alu_q.push_back(e);
    end
    if (l_acc) begin
      e.idx = bus.in_ls_dst_rob_index; e.value = bus.in_ls_value;
      e.set_nzcv = 1'b0; e.nzcv = 4'd0; e.mis = 1'b0; e.due = 0;
      ls_q.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive_alu(input bit d, input logic [IDX-1:0] idx, input logic [GPR-1:0] v,
                           input bit s, input logic [3:0] f, input bit m);
    bus.in_alu_done          = d & bus.out_alu_ready;
    bus.in_alu_dst_rob_index = idx;
    bus.in_alu_value         = v;
    bus.in_alu_set_nzcv      = s;
    bus.in_alu_nzcv          = f;
    bus.in_alu_is_mispred    = m;
  endtask

  task automatic drive_ls(input bit d, input logic [IDX-1:0] idx, input logic [GPR-1:0] v);
    bus.in_ls_done          = d & bus.out_ls_ready;
    bus.in_ls_dst_rob_index = idx;
    bus.in_ls_value         = v;
  endtask

  task automatic idle();
    drive_alu(1'b0, 4'd0, 64'd0, 1'b0, 4'd0, 1'b0);
    drive_ls(1'b0, 4'd0, 64'd0);
  endtask

  function automatic logic [GPR-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Monitor: compares readiness every cycle and the ROB port against due results.
  initial begin : monitor
    res_t e;
    forever begin
      @(negedge clk);
      if (started) begin
        chk("alu_ready", 64'(bus.out_alu_ready), 64'(alu_q.size() < DEPTH));
        chk("ls_ready", 64'(bus.out_ls_ready), 64'(ls_q.size() < DEPTH));
        if (exp_q.size() > 0 && exp_q[0].due == edge_cnt) begin
          e = exp_q.pop_front();
          chk("rob_done", 64'(bus.out_rob_done), 64'd1);
          chk("rob_idx", 64'(bus.out_rob_dst_rob_index), 64'(e.idx));
          chk("rob_value", 64'(bus.out_rob_value), 64'(e.value));
          chk("rob_set_nzcv", 64'(bus.out_rob_set_nzcv), 64'(e.set_nzcv));
          chk("rob_nzcv", 64'(bus.out_rob_nzcv), 64'(e.nzcv));
          chk("rob_mispred", 64'(bus.out_rob_is_mispred), 64'(e.mis));
        end else begin
          chk("rob_idle_done", 64'(bus.out_rob_done), 64'd0);
          chk("rob_idle_value", 64'(bus.out_rob_value), 64'd0);
          chk("rob_idle_fields", 64'({bus.out_rob_dst_rob_index, bus.out_rob_set_nzcv,
                                      bus.out_rob_nzcv, bus.out_rob_is_mispred}), 64'd0);
        end
      end
    end
  end

  initial begin : driver
    logic [IDX-1:0] ls_idx;
    logic [IDX-1:0] alu_idx;
    bus.in_flush = 1'b0;
    idle();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step();

    // Single ALU result with flags.
    drive_alu(1'b1, 4'd3, 64'h2A, 1'b1, 4'b0100, 1'b0);
    step(); idle();
    repeat (4) step();

    // Mispredicted branch result.
    drive_alu(1'b1, 4'd5, rnd64(), 1'b0, 4'd0, 1'b1);
    step(); idle();
    repeat (3) step();

    // Reset with results still buffered, then simultaneous results.
    drive_alu(1'b1, 4'd9, rnd64(), 1'b1, 4'hF, 1'b0);
    drive_ls(1'b1, 4'd10, rnd64());
    step();
    drive_alu(1'b1, 4'd11, rnd64(), 1'b0, 4'd0, 1'b0);
    drive_ls(1'b1, 4'd12, rnd64());
    step();
    idle(); rst = 1'b1;
    step();
    rst = 1'b0;
    drive_alu(1'b1, 4'd1, rnd64(), 1'b1, 4'b1010, 1'b0);
    drive_ls(1'b1, 4'd2, rnd64());
    step(); idle();
    repeat (4) step();

    // Fill both FIFOs, then flush while the ALU presents idx 7.
    for (int i = 0; i < 3; i++) begin
      drive_alu(1'b1, 4'(8 + i), rnd64(), 1'b0, 4'd0, 1'b0);
      drive_ls(1'b1, 4'(12 + i), rnd64());
      step();
    end
    idle();
    bus.in_flush = 1'b1;
    drive_alu(1'b1, 4'd7, rnd64(), 1'b1, 4'd1, 1'b1);
    step();
    bus.in_flush = 1'b0; idle();
    repeat (4) step();

    // LS streams every cycle under backpressure while the ALU issues randomly.
    ls_idx  = 4'd0;
    alu_idx = 4'd0;
    for (int c = 0; c < 800; c++) begin
      rst          = ($urandom_range(0, 199) == 0);
      bus.in_flush = ($urandom_range(0, 39) == 0);
      drive_ls(1'b1, ls_idx, rnd64());
      drive_alu($urandom_range(0, 3) != 0, alu_idx, rnd64(), 1'($urandom),
                4'($urandom), ($urandom_range(0, 7) == 0));
      if (bus.in_ls_done && !bus.in_flush && !rst) ls_idx = ls_idx + 4'd1;
      if (bus.in_alu_done && !bus.in_flush && !rst) alu_idx = alu_idx + 4'd1;
      step();
    end
    rst = 1'b0; bus.in_flush = 1'b0; idle();
    repeat (8) step();
    @(negedge clk); #1;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
